// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan
// Description : Time-multiplexed seven-segment display driver. A prescaler
//               divides clk into digit slots; each slot starts with a short
//               all-off window to avoid ghosting, then lights one digit.
//               New data is captured into a shadow register on load and is
//               moved to the display register only at frame start, so a
//               frame never mixes old and new data.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset
//               value      - hex nibbles, nibble i drives digit i
//               dp_in      - per-digit decimal point (1 = lit)
//               blank_in   - per-digit force blank (1 = digit off)
//               load       - capture strobe for value/dp_in/blank_in/lz_blank
//               lz_blank   - leading-zero blanking enable
//               segout     - {dp, g..a}, registered, polarity per parameter
//               digit_sel  - one-hot digit enable, registered
//               frame_done - one-cycle pulse at the start of each new frame
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 1000,
    parameter int BLANK_CYC      = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    input  logic                    lz_blank,
    output logic [7:0]              segout,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0]            SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                               : {NUM_DIGITS{1'b0}};

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    logic [PW-1:0]             presc_q, presc_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   shd_val_q, shd_val_d, disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]     shd_dp_q, shd_dp_d, disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0]     shd_bl_q, shd_bl_d, disp_bl_q, disp_bl_d;
    logic                      shd_lz_q, shd_lz_d, disp_lz_q, disp_lz_d;
    logic                      wrap_q, wrap_d;
    logic                      frame_done_q, frame_done_d;
    logic [7:0]                segout_q, segout_d;
    logic [NUM_DIGITS-1:0]     digit_sel_q, digit_sel_d;

    logic                      presc_term;
    logic                      idx_last;
    logic                      zero_run;
    logic [NUM_DIGITS-1:0]     lz_mask;
    logic [NUM_DIGITS-1:0]     one_hot;
    logic [3:0]                cur_nib;
    logic                      cur_dp;
    logic                      cur_off;
    logic [7:0]                pattern;

    always_comb begin
        presc_term = (presc_q == PW'(CLK_DIV - 1));
        idx_last   = (idx_q == IW'(NUM_DIGITS - 1));
        wrap_d     = presc_term && idx_last;

        presc_d = presc_term ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_term) begin
            idx_d = idx_last ? '0 : idx_q + IW'(1);
        end

        // Shadow always accepts a load; the display only takes the shadow
        // as it stood before this edge, so a load coinciding with frame
        // start is deferred to the following frame.
        shd_val_d = load ? value    : shd_val_q;
        shd_dp_d  = load ? dp_in    : shd_dp_q;
        shd_bl_d  = load ? blank_in : shd_bl_q;
        shd_lz_d  = load ? lz_blank : shd_lz_q;

        disp_val_d = wrap_d ? shd_val_q : disp_val_q;
        disp_dp_d  = wrap_d ? shd_dp_q  : disp_dp_q;
        disp_bl_d  = wrap_d ? shd_bl_q  : disp_bl_q;
        disp_lz_d  = wrap_d ? shd_lz_q  : disp_lz_q;

        // Leading-zero mask: walk from the most significant digit down,
        // blanking while every nibble seen so far is zero. Digit 0 is exempt.
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run && (disp_val_q[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run && (i > 0) && disp_lz_q;
        end

        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_off = 1'b0;
        one_hot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            one_hot[i] = (idx_q == IW'(i));
            if (idx_q == IW'(i)) begin
                cur_nib = disp_val_q[4*i +: 4];
                cur_dp  = disp_dp_q[i];
                cur_off = disp_bl_q[i] || lz_mask[i];
            end
        end

        pattern = cur_off ? 8'h00 : {cur_dp, hex7(cur_nib)};

        if (presc_q < PW'(BLANK_CYC)) begin
            segout_d    = SEG_OFF;
            digit_sel_d = DIG_OFF;
        end else begin
            segout_d    = pattern ^ SEG_OFF;
            digit_sel_d = one_hot ^ DIG_OFF;
        end

        // wrap_q marks presc/idx = 0/0; one more stage lines the pulse up
        // with the registered first blanked output of digit 0.
        frame_done_d = wrap_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            shd_val_q    <= '0;
            shd_dp_q     <= '0;
            shd_bl_q     <= '0;
            shd_lz_q     <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            disp_bl_q    <= '0;
            disp_lz_q    <= 1'b0;
            wrap_q       <= 1'b0;
            frame_done_q <= 1'b0;
            segout_q     <= SEG_OFF;
            digit_sel_q  <= DIG_OFF;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            shd_val_q    <= shd_val_d;
            shd_dp_q     <= shd_dp_d;
            shd_bl_q     <= shd_bl_d;
            shd_lz_q     <= shd_lz_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            disp_bl_q    <= disp_bl_d;
            disp_lz_q    <= disp_lz_d;
            wrap_q       <= wrap_d;
            frame_done_q <= frame_done_d;
            segout_q     <= segout_d;
            digit_sel_q  <= digit_sel_d;
        end
    end

    assign segout     = segout_q;
    assign digit_sel  = digit_sel_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 Parameter CLK_DIV, default 1000, clock cycles per digit slot (>= 2).
REQ-003 Parameter BLANK_CYC, default 4, cycles at the start of each slot with all digits off (anti-ghosting; < CLK_DIV).
REQ-004 Parameter SEG_ACTIVE_LOW, default 1, segment output polarity (1 = lit segment driven 0).
REQ-005 Parameter DIG_ACTIVE_LOW, default 1, digit-enable polarity (1 = selected digit driven 0).
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 value  input  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i, digit 0 least significant.
REQ-009 dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit.
REQ-010 blank_in  input  NUM_DIGITS  per-digit force-blank, 1 = all segments of that digit off.
REQ-011 load  input  1  capture strobe for value/dp_in/blank_in.
REQ-012 lz_blank  input  1  leading-zero blanking enable, sampled with load.
REQ-013 segout  output  8  bit0..6 = segments a..g, bit7 = dp; polarity per SEG_ACTIVE_LOW; registered.
REQ-014 digit_sel  output  NUM_DIGITS  one-hot digit enable; polarity per DIG_ACTIVE_LOW; registered.
REQ-015 frame_done  output  1  one-cycle pulse when the scan wraps from the last digit to digit 0.

Function
REQ-016 Prescaler SHALL count 0..CLK_DIV-1 and wrap; at terminal count, digit index SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0.
REQ-017 When load = 1 on a rising edge, value, dp_in, blank_in, and lz_blank SHALL be captured into a shadow register; the last load before a frame start wins.
REQ-018 The display register SHALL copy the shadow register only on the cycle the digit index wraps to 0 (frame start), so no frame ever shows mixed old/new data; the latency from load to display is at most one full frame.
REQ-019 A load on the same cycle as the frame-start copy SHALL NOT reach the display that frame; it is taken at the next frame start.
REQ-020 Hex decode (a..g, 1 = lit) SHALL be: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-021 With lz_blank = 1, digit i > 0 SHALL be blanked when nibbles NUM_DIGITS-1 down to i are all zero; digit 0 SHALL never be blanked by this rule; dp on a blanked digit SHALL also be off.
REQ-022 blank_in SHALL override decode and dp for its digit.
REQ-023 During prescaler counts 0..BLANK_CYC-1 of each slot, digit_sel SHALL be all inactive and segout all inactive; for the remaining counts, digit_sel SHALL select the current index and segout SHALL show that digit's pattern.
REQ-024 Outputs SHALL be registered: segout/digit_sel reflect the prescaler/index state of the previous cycle (1-cycle latency, constant).
REQ-025 frame_done SHALL assert for exactly one cycle, the cycle after index transitions NUM_DIGITS-1 -> 0, aligned with the first blanked cycle of digit 0's slot.
REQ-026 With NUM_DIGITS = 1, the index SHALL stay 0 and frame_done SHALL pulse every CLK_DIV cycles.

Reset
REQ-027 While rst_n = 0: prescaler = 0, index = 0, shadow and display registers = 0 (lz_blank = 0), digit_sel all inactive, segout all inactive, frame_done = 0, all asynchronously.
REQ-028 After rst_n deasserts, the first slot SHALL begin at prescaler 0 with digit 0, and the display SHALL show 0 on all digits until a loaded value reaches a frame start.
REQ-029 A reset mid-frame SHALL discard the shadow contents and any pending load.

Verification (NUM_DIGITS=4, CLK_DIV=4, BLANK_CYC=1, active-low)
REQ-030 Reset release, no load -> digit_sel cycles 1110,1101,1011,0111 (each active 3 of 4 cycles, 1111 in between), segout = C0 in lit cycles, frame_done every 16 cycles.
REQ-031 load value=16'h1B2D, dp_in=0 -> from the next frame start, digit0 = A1 (d), digit1 = A4 (2), digit2 = 83 (b), digit3 = F9 (1).
REQ-032 load value=16'h0050, lz_blank=1 -> digit3 and digit2 = FF, digit1 = 92 (5), digit0 = C0 (0); value=0 -> only digit0 lit, C0.
REQ-033 dp_in=4'b0100, blank_in=4'b0001, value=16'h8888 -> digit2 = 00, digit0 = FF, others = 80.
REQ-034 Two loads mid-frame (1111 then 2222) -> the display changes directly from old to 2222 at the frame start; never a mixed frame.
REQ-035 rst_n pulsed low mid-slot with a pending load -> outputs inactive immediately; after release, the scan restarts at digit 0 showing 0000.
